// File: rtl/golomb_pkg.sv
// Field layout shared by the Golomb encoder and decoder so both ends agree on
// divisor, remainder and run-length widths.
package golomb_pkg;

  localparam int M_W   = 8;
  localparam int REM_W = 8;
  localparam int RUN_W = 16;

  typedef enum logic [1:0] {
    UNARY = 2'd0,
    REM   = 2'd1,
    OUT   = 2'd2
  } state_e;

endpackage

// File: rtl/golomb_decoder_if.sv
// Bit-stream input and run-length output handshakes of the Golomb decoder.
interface golomb_decoder_if #(
  parameter int M_W   = golomb_pkg::M_W,
  parameter int RUN_W = golomb_pkg::RUN_W
) ();

  logic [M_W-1:0]   m;
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [RUN_W-1:0] run_len;
  logic             run_err;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output m, bit_in, bit_valid, out_ready,
    input  bit_ready, run_len, run_err, out_valid, busy
  );

  modport slave (
    input  m, bit_in, bit_valid, out_ready,
    output bit_ready, run_len, run_err, out_valid, busy
  );

endinterface

// File: rtl/golomb_sat_add.sv
// Unsigned adder that clamps to all-ones on carry-out and flags the overflow.
module golomb_sat_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  logic [W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b};
  assign o_ovf  = w_full[W];
  assign o_sum  = w_full[W] ? {W{1'b1}} : w_full[W-1:0];

endmodule

// File: rtl/golomb_decoder.sv
// Serial Golomb decoder: unary quotient, zero terminator, fixed-width remainder
// in; saturated run length plus error flag out on a valid/ready port.
module golomb_decoder #(
  parameter int M_W   = golomb_pkg::M_W,
  parameter int REM_W = golomb_pkg::REM_W,
  parameter int RUN_W = golomb_pkg::RUN_W
) (
  input  logic            clk,
  input  logic            rst_n,
  golomb_decoder_if.slave bus
);
  import golomb_pkg::*;

  localparam int CNT_W = $clog2(REM_W + 1);

  localparam logic [1:0] ST_UNARY = UNARY;
  localparam logic [1:0] ST_REM   = REM;
  localparam logic [1:0] ST_OUT   = OUT;

  logic [1:0]       r_state;
  logic [M_W-1:0]   r_m;
  logic [RUN_W-1:0] r_acc;
  logic [REM_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_busy;
  logic [RUN_W-1:0] r_run_len;
  logic             r_run_err;

  logic             w_xfer;
  logic             w_first;
  logic [M_W-1:0]   w_m_eff;
  logic [REM_W-1:0] w_rem_next;
  logic [RUN_W-1:0] w_acc_q;
  logic             w_ovf_q;
  logic [RUN_W-1:0] w_sum_r;
  logic             w_ovf_r;
  logic             w_rem_bad;
  logic             w_last_rem;

  assign bus.bit_ready = (r_state != ST_OUT);
  assign bus.out_valid = (r_state == ST_OUT);
  assign bus.run_len   = r_run_len;
  assign bus.run_err   = r_run_err;
  assign bus.busy      = r_busy;

  assign w_xfer     = bus.bit_valid && bus.bit_ready;
  // The first bit of a codeword must already use the divisor being sampled.
  assign w_first    = !r_busy;
  assign w_m_eff    = w_first ? bus.m : r_m;
  assign w_rem_next = {r_rem[REM_W-2:0], bus.bit_in};
  assign w_rem_bad  = RUN_W'(w_rem_next) >= RUN_W'(r_m);
  assign w_last_rem = (r_cnt == CNT_W'(REM_W - 1));

  golomb_sat_add #(.W(RUN_W)) u_add_q (
    .i_a   (r_acc),
    .i_b   (RUN_W'(w_m_eff)),
    .o_sum (w_acc_q),
    .o_ovf (w_ovf_q)
  );

  golomb_sat_add #(.W(RUN_W)) u_add_r (
    .i_a   (r_acc),
    .i_b   (RUN_W'(w_rem_next)),
    .o_sum (w_sum_r),
    .o_ovf (w_ovf_r)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_UNARY;
      r_m       <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
      r_run_len <= '0;
      r_run_err <= 1'b0;
    end else begin
      case (r_state)
        ST_UNARY: begin
          if (w_xfer) begin
            if (w_first) begin
              r_m    <= bus.m;
              r_busy <= 1'b1;
            end
            r_err <= r_err | (w_first && (bus.m == '0)) | (bus.bit_in && w_ovf_q);
            if (bus.bit_in) begin
              r_acc <= w_acc_q;
            end else begin
              r_state <= ST_REM;
              r_cnt   <= '0;
            end
          end
        end
        ST_REM: begin
          if (w_xfer) begin
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last_rem) begin
              r_run_len <= w_sum_r;
              r_run_err <= r_err | w_ovf_r | w_rem_bad;
              r_state   <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            r_acc     <= '0;
            r_rem     <= '0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_run_err <= 1'b0;
            r_state   <= ST_UNARY;
          end
        end
        default: r_state <= ST_UNARY;
      endcase
    end
  end

endmodule

// File: tb/tb_golomb_decoder.sv
// Randomized and directed bench for golomb_decoder against an arithmetic model
// of the codeword (n = q*m + r, clamped, with error rules).
module tb_golomb_decoder;

  typedef struct {
    logic [15:0] len;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  golomb_decoder_if bus ();

  golomb_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q_exp[$];
  int   rdy_mode = 0;
  bit   gap_en   = 0;
  bit   mon_en   = 0;

  bit          prev_hold = 0;
  logic [15:0] prev_len;
  logic        prev_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: whole-codeword arithmetic, clamped at 16 bits.
  task automatic ref_decode(input int mv, input int q, input int r,
                            output logic [15:0] len, output logic err);
    longint n;
    n   = longint'(q) * longint'(mv) + longint'(r);
    err = (mv == 0) || (r >= mv) || (n > 65535);
    len = (n > 65535) ? 16'hFFFF : 16'(n);
  endtask

  task automatic push_exp(input logic [15:0] len, input logic err);
    exp_t e;
    e.len = len;
    e.err = err;
    q_exp.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the edge that took the bit.
  task automatic put_bit(input logic b);
    int waited;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      bus.bit_valid = 1'b0;
      bus.bit_in    = 1'($urandom);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.bit_ready) break;
      waited++;
      if (waited > 2000) begin
        chk("bit_ready_timeout", 32'(waited), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input int mv, input int q, input int r, input bit chg_m);
    logic [7:0] rb;
    rb = 8'(r);
    bus.m = 8'(mv);
    for (int i = 0; i < q; i++) begin
      put_bit(1'b1);
      if (chg_m && i == 0) bus.m = 8'($urandom);
    end
    put_bit(1'b0);
    if (chg_m && q == 0) bus.m = 8'($urandom);
    for (int i = 7; i >= 0; i--) put_bit(rb[i]);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 2) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Compare process: output handshakes against the expected queue, hold stability.
  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      prev_hold = 0;
    end else begin
      chk("ready_vs_valid", 32'(bus.bit_ready), 32'(!bus.out_valid));
      if (prev_hold && bus.out_valid) begin
        chk("hold_len", 32'(bus.run_len), 32'(prev_len));
        chk("hold_err", 32'(bus.run_err), 32'(prev_err));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q_exp.size() == 0) begin
          chk("unexpected_output", 32'(bus.run_len), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = q_exp.pop_front();
          chk("run_len", 32'(bus.run_len), 32'(e.len));
          chk("run_err", 32'(bus.run_err), 32'(e.err));
        end
        prev_hold = 0;
      end else if (bus.out_valid) begin
        prev_hold = 1;
        prev_len  = bus.run_len;
        prev_err  = bus.run_err;
      end else begin
        prev_hold = 0;
      end
    end
  end

  initial begin
    logic [15:0] l;
    logic        e;
    int          mv, q, r, waited;

    rst_n         = 1'b0;
    bus.m         = '0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;

    // Pin the model with hand-derived values.
    ref_decode(4, 2, 3, l, e);
    chk("model_4_2_3_len", 32'(l), 32'd11);
    chk("model_4_2_3_err", 32'(e), 32'd0);
    ref_decode(255, 258, 0, l, e);
    chk("model_sat_len", 32'(l), 32'hFFFF);
    chk("model_sat_err", 32'(e), 32'd1);
    ref_decode(255, 257, 0, l, e);
    chk("model_max_err", 32'(e), 32'd0);
    ref_decode(4, 0, 5, l, e);
    chk("model_rem_err", 32'(e), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_bit_ready", 32'(bus.bit_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_run_len", 32'(bus.run_len), 32'd0);
    chk("rst_run_err", 32'(bus.run_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1;
    @(posedge clk);
    #1;

    // m=4, q=2, r=3 with latency check.
    push_exp(16'd11, 1'b0);
    send_bits(4, 2, 3, 0);
    chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
    bus.bit_valid = 1'b0;

    push_exp(16'd5, 1'b0);
    send_bits(10, 0, 5, 0);
    push_exp(16'd5, 1'b1);
    send_bits(4, 0, 5, 0);
    push_exp(16'd8, 1'b0);
    send_bits(6, 1, 2, 0);
    push_exp(16'hFFFF, 1'b1);
    send_bits(255, 258, 0, 0);
    push_exp(16'hFFFF, 1'b0);
    send_bits(255, 257, 0, 0);

    // Backpressure: next codeword's first bit stays offered while output stalls.
    rdy_mode = 2;
    push_exp(16'd7, 1'b0);
    send_bits(5, 1, 2, 0);
    push_exp(16'd9, 1'b0);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("bp_bit_ready", 32'(bus.bit_ready), 32'd0);
          chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        @(posedge clk);
        rdy_mode = 0;
      end
      send_bits(3, 3, 0, 0);
    join
    bus.bit_valid = 1'b0;

    // Reset mid-codeword.
    repeat (3) @(posedge clk);
    #1;
    bus.m = 8'd3;
    put_bit(1'b1);
    put_bit(1'b1);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_bit_ready", 32'(bus.bit_ready), 32'd1);
    bus.bit_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_exp(16'd5, 1'b0);
    send_bits(3, 1, 2, 0);

    // Randomized traffic with gaps, random output stalls and mid-codeword m changes.
    gap_en   = 1;
    rdy_mode = 1;
    for (int k = 0; k < 60; k++) begin
      mv = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
      r  = int'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) begin
        mv = int'($urandom_range(200, 255));
        q  = int'($urandom_range(250, 300));
      end else begin
        q  = int'($urandom_range(0, 12));
      end
      ref_decode(mv, q, r, l, e);
      push_exp(l, e);
      send_bits(mv, q, r, 1);
    end
    bus.bit_valid = 1'b0;
    gap_en = 0;

    waited = 0;
    while (q_exp.size() != 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    chk("drain_queue_empty", 32'(q_exp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/golomb_decoder.md
# golomb_decoder

Serial Golomb decoder, the receive-side counterpart of the Golomb encoder. It consumes a codeword bitstream one bit per cycle under a valid/ready handshake and reconstructs each zero-run length `n = q*m + r`. Each decoded run is presented on a valid/ready output port. It sits between the compressed-stream deserializer and the run-length expander.

## Interface
Parameters:
- `M_W`, 8: width of divisor `m`.
- `REM_W`, 8: fixed remainder field width, sent MSB first.
- `RUN_W`, 16: width of the decoded run length.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `m`  in  M_W  Golomb divisor; sampled on the first accepted bit of each codeword.
- `bit_in`  in  1  codeword bit.
- `bit_valid`  in  1  `bit_in` valid.
- `bit_ready`  out  1  decoder accepts a bit this cycle.
- `run_len`  out  RUN_W  decoded run length.
- `run_err`  out  1  decoded word is erroneous (see Operation).
- `out_valid`  out  1  `run_len`/`run_err` valid.
- `out_ready`  in  1  downstream accepts output.
- `busy`  out  1  a codeword is partially received.

## Operation
- **Codeword format:**
  - `q` one-bits (unary quotient).
  - One zero-bit (terminator).
  - `r` in exactly REM_W bits, MSB first.
- **Bit transfer:** a bit transfers when `bit_valid && bit_ready` at a rising edge.
- **States:**
  - UNARY: `bit_ready`=1.
    - First transferred bit of a codeword latches `m_q <= m` and sets `busy`.
    - Bit 1: `acc <= acc + m_q`, with saturation.
    - Bit 0: go to REM, remainder bit counter cleared.
  - REM: `bit_ready`=1.
    - Each transferred bit shifts into `rem` (MSB first).
    - After the REM_W-th bit: `run_len <= acc + rem` (saturating), go to OUT.
  - OUT: `bit_ready`=0, `out_valid`=1, outputs held stable.
    - On `out_ready`: clear `acc`, `rem`, `busy` and the error flag, return to UNARY.
- **Arithmetic:**
  - `acc` is RUN_W bits wide. Any sum exceeding 2^RUN_W−1 saturates to all-ones and sets the sticky error.
  - `m_q` is zero-extended to RUN_W.
- **`run_err` is set if any of:**
  - `m_q == 0`, checked at sampling.
  - `rem >= m_q`, checked at the end of REM.
  - Saturation occurred.
- **Error handling:** an erroneous word is still emitted. `run_len` carries the saturated or raw sum. The decoder never stalls on error.
- **Changes to `m`:** changing `m` mid-codeword has no effect until the next codeword.

## Timing
- **Reset values:**
  - `bit_ready`=1.
  - `out_valid`=0, `run_len`=0, `run_err`=0, `busy`=0.
  - State UNARY; `acc`, `rem` and counters are 0.
- **Latency:** `out_valid` rises the cycle after the last remainder bit transfers.
- **Throughput:** a codeword of L bits occupies L transfer cycles, plus ≥1 OUT cycle. The next codeword's first bit transfers no earlier than the cycle after the output handshake.
- **Backpressure:**
  - While `out_ready`=0 in OUT, no input bit is consumed, whatever `bit_valid` does.
  - `run_len`/`run_err` stay constant.
- **Input stalls:** `bit_valid`=0 at any point leaves all state unchanged. Gaps are legal in UNARY and REM.
- **Reset mid-codeword:** `rst_n` low at any time immediately returns all outputs to reset values and discards the partial codeword. The first bit after release starts a new codeword.
- **Saturation:** once saturated, further unary ones keep `acc` at all-ones.

## Structure
- **Shared package `golomb_pkg`:**
  - Constants `M_W`, `REM_W`, `RUN_W`.
  - State enum `{UNARY, REM, OUT}`.
  - Shared with the encoder so the field layout cannot diverge.
- **Sub-module `golomb_sat_add`:**
  - Combinational RUN_W saturating adder with an overflow flag.
  - Used for both the `acc + m_q` and `acc + rem` updates.
- **Top-level:** FSM, remainder shift register, REM_W-bit counter, output register.

## Test plan
- m=4, bits 1,1,0,00000011 → `run_len`=11, `run_err`=0. `out_valid` rises one cycle after the 11th transferred bit.
- m=10, bits 0,00000101 → `run_len`=5, `run_err`=0. This is the q=0 path.
- m=4, bits 0,00000101 → `run_len`=5, `run_err`=1 (r ≥ m). The next codeword decodes cleanly with `run_err`=0.
- m=255, 258 ones then 0,00000000 → `run_len`=16'hFFFF, `run_err`=1. Repeat with 257 ones → 65535, `run_err`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles with `bit_valid`=1 → `bit_ready`=0, outputs stable, no bits lost. The following codeword decodes correctly.
- Reset mid-codeword: send 1,1, pulse `rst_n` low → `busy`=0, `out_valid`=0. Then m=3, bits 1,0,00000010 → `run_len`=5.
